id_stage_pipe: RTL
==================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width (32 or 64).
REQ-002 SHALL have parameter NREG, 32, architectural register count (32, or 16 for RV32E).
REQ-003 SHALL have parameter CTRL_W, 25, width of the opaque control bundle from the external decoders.
REQ-004 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset), with reset rst asynchronous, active-low, and clock clk.
REQ-005 SHALL have in_valid, input, 1, IF stage has an instruction.
REQ-006 SHALL have in_ready, output, 1, ID accepts the instruction this cycle.
REQ-007 SHALL have in_inst, input, 32, instruction word.
REQ-008 SHALL have in_pc, input, XLEN, instruction PC.
REQ-009 SHALL have in_ctrl, input, CTRL_W, decoded control bundle.
REQ-010 SHALL have flush, input, 1, kill the ID/EX contents (branch redirect).
REQ-011 SHALL have ex_stall, input, 1, EX cannot accept.
REQ-012 SHALL have wb_we, input, 1; wb_addr, input, 5; wb_data, input, XLEN; these form the regfile write port.
REQ-013 SHALL have ex_rd_en, input, 1; ex_rd, input, 5; ex_data, input, XLEN; ex_is_load, input, 1; these describe the EX result.
REQ-014 SHALL have mem_rd_en, input, 1; mem_rd, input, 5; mem_data, input, XLEN; these describe the MEM result.
REQ-015 SHALL have out_valid, output, 1; out_ctrl, output, CTRL_W; out_inst, output, 32; out_pc, output, XLEN; out_rd, output, 5; these are registered ID/EX outputs.
REQ-016 SHALL have out_rs1_data, out_rs2_data, out_imm and out_pc_imm, each output, XLEN, registered.
REQ-017 SHALL have hazard_stall, output, 1, combinational load-use indication.

Function
REQ-018 SHALL contain NREG x XLEN registers; x0 reads 0; writes to x0 or to any address >= NREG are ignored; reads of addresses >= NREG return 0.
REQ-019 SHALL resolve each source (rs1 = inst[19:15], rs2 = inst[24:20]) with this priority: index 0 gives 0; then EX match (ex_rd_en and not ex_is_load); then MEM match; then WB match (write-through); then the array.
REQ-020 SHALL generate imm sign-extended to XLEN by opcode: I for 0010011, 0000011, 1100111; S for 0100011; B for 1100011; U for 0110111 and 0010111; J for 1101111; imm = 0 for any other opcode.
REQ-021 SHALL compute out_pc_imm = in_pc + imm modulo 2^XLEN.
REQ-022 SHALL assert hazard_stall = in_valid and ex_rd_en and ex_is_load and ex_rd != 0 and (ex_rd == rs1 or ex_rd == rs2).
REQ-023 SHALL drive in_ready = flush or (not ex_stall and not hazard_stall).
REQ-024 SHALL give ID/EX register update priority per cycle as: flush, then ex_stall, then hazard_stall, then normal.
REQ-025 SHALL, on flush, set out_valid to 0 next cycle and discard the input, regardless of ex_stall.
REQ-026 SHALL, on ex_stall without flush, hold all out_* registers unchanged.
REQ-027 SHALL, on hazard_stall without flush or ex_stall, insert a bubble: out_valid <= 0 and out_ctrl <= 0, with the input not consumed.
REQ-028 SHALL, in normal operation, load all out_* registers in the next cycle, with out_valid <= in_valid; latency is 1 cycle.
REQ-029 SHALL perform the regfile write on the clk edge when wb_we is set, independent of stall or flush.

Reset
REQ-030 SHALL, while rst = 0, asynchronously clear every out_* register and every regfile entry to 0; in_ready then follows REQ-023.
REQ-031 SHALL, on reset during a stall or hazard, clear state, with the first accepted instruction after reset release appearing 1 cycle later.

Verification
REQ-032 SHALL cover: write x5 = 0x1234 via WB, then addi x6,x5,1 (0x00128313) -> out_rs1_data = 0x1234 and out_imm = 1.
REQ-033 SHALL cover: the same-cycle wb write x7 = 0xAA with a read of x7 -> out_rs1_data = 0xAA (write-through).
REQ-034 SHALL cover: EX x8 = 5, MEM x8 = 9, WB x8 = 3 with a read of x8 -> result 5; with EX disabled -> 9.
REQ-035 SHALL cover: ex_is_load, ex_rd = 10 and an instruction using x10 -> hazard_stall = 1, in_ready = 0 and a one-cycle bubble, then issue with the forwarded value.
REQ-036 SHALL cover: flush and ex_stall together -> out_valid = 0 next cycle; ex_stall alone for 3 cycles -> outputs held bit-exact.
REQ-037 SHALL cover: beq with imm = -8 at pc 0x100 -> out_imm = all-ones...FFF8 and out_pc_imm = 0xF8, for XLEN = 32 and XLEN = 64.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Instruction-decode pipeline stage: register-file read with bypassing, immediate
// generation, load-use hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CTRL_W = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_rd_en,
  input  logic [4:0]        ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              ex_is_load,
  input  logic              mem_rd_en,
  input  logic [4:0]        mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_inst,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc_imm,
  output logic              hazard_stall
);

  localparam int unsigned AW = 5;

  logic [XLEN-1:0] rf [NREG];
  logic [AW-1:0]   rs1_c, rs2_c;
  logic [XLEN-1:0] rs1_val_c, rs2_val_c, imm_c, pc_imm_c;

  assign rs1_c = in_inst[19:15];
  assign rs2_c = in_inst[24:20];

  // Register file; x0 is never written and the write port ignores out-of-range addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (wb_we && wb_addr == AW'(i)) rf[i] <= wb_data;
      end
    end
  end

  // Source operand with EX > MEM > WB > array priority; the WB bypass only
  // applies to addresses the array actually holds.
  function automatic logic [XLEN-1:0] resolve(input logic [AW-1:0] a);
    logic [XLEN-1:0] arr;
    logic            hit;
    arr = '0;
    hit = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (a == AW'(i)) begin
        arr = rf[i];
        hit = 1'b1;
      end
    end
    if (a == '0)                                  return '0;
    else if (ex_rd_en && !ex_is_load && ex_rd == a) return ex_data;
    else if (mem_rd_en && mem_rd == a)            return mem_data;
    else if (wb_we && wb_addr == a && hit)        return wb_data;
    else                                          return arr;
  endfunction

  always_comb begin
    rs1_val_c = resolve(rs1_c);
    rs2_val_c = resolve(rs2_c);
  end

  // Sign-extended immediate selected by opcode format.
  always_comb begin
    imm_c = '0;
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm_c = XLEN'($signed(in_inst[31:20]));
      7'b0100011:
        imm_c = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      7'b1100011:
        imm_c = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      7'b0110111, 7'b0010111:
        imm_c = XLEN'($signed({in_inst[31:12], 12'b0}));
      7'b1101111:
        imm_c = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      default:
        imm_c = '0;
    endcase
  end

  assign pc_imm_c = in_pc + imm_c;

  assign hazard_stall = in_valid && ex_rd_en && ex_is_load && (ex_rd != '0) &&
                        ((ex_rd == rs1_c) || (ex_rd == rs2_c));
  assign in_ready     = flush || (!ex_stall && !hazard_stall);

  // ID/EX register: flush > ex_stall > hazard bubble > normal load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_ctrl     <= '0;
      out_inst     <= '0;
      out_pc       <= '0;
      out_rd       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_pc_imm   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ex_stall) begin
      out_valid <= out_valid;
    end else if (hazard_stall) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else begin
      out_valid    <= in_valid;
      out_ctrl     <= in_ctrl;
      out_inst     <= in_inst;
      out_pc       <= in_pc;
      out_rd       <= in_inst[11:7];
      out_rs1_data <= rs1_val_c;
      out_rs2_data <= rs2_val_c;
      out_imm      <= imm_c;
      out_pc_imm   <= pc_imm_c;
    end
  end

endmodule
